hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the ID/EX stage of the RV32 integer+float core. It detects load-use hazards, controls multi-cycle float ops, handles taken-branch flushes and data-memory wait freezes. From these it generates the stall, bubble, hold and flush controls for the IF/ID and ID/EX registers, plus the WB-to-ID/EX forwarding selects (reg1_sel/reg2_sel). Register addresses are 6-bit unified: 0-31 integer (x0 hard-zero), 32-63 float.

---
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ID/EX hazard and sequencing controller: load-use stalls, multi-cycle float
// sequencing, branch flushes, memory-wait freezes and WB->ID/EX forwarding selects.
module hazard_ctrl #(
  parameter int MC_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [5:0]  id_rs1_addr,
  input  logic [5:0]  id_rs2_addr,
  input  logic        id_rs1_use,
  input  logic        id_rs2_use,
  input  logic        id_is_mc,
  input  logic [5:0]  ex_rd_addr,
  input  logic        ex_wb_en,
  input  logic        ex_is_load,
  input  logic [5:0]  wb_rd_addr,
  input  logic        wb_wb_en,
  input  logic        branch_taken_ex,
  input  logic        mem_stall,
  output logic        stall_if,
  output logic        stall_id,
  output logic        ex_hold,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic        reg1_sel,
  output logic        reg2_sel,
  output logic        mc_busy,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  // Handshake-free block: every control is a level, valid in the cycle it is driven;
  // the pipeline samples them at the next rising clk edge.

  typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_t;

  state_t     state;
  logic [3:0] mc_cnt;

  // Address 0 is x0 (hard zero); address 32 is f0, a real register.
  function automatic logic src_hit(input logic use_src, input logic [5:0] src,
                                   input logic [5:0] dst);
    return use_src && (src == dst) && (dst != 6'd0);
  endfunction

  logic load_use;
  logic mc_issue;
  logic run_state;

  assign load_use  = id_valid && ex_is_load && ex_wb_en &&
                     (src_hit(id_rs1_use, id_rs1_addr, ex_rd_addr) ||
                      src_hit(id_rs2_use, id_rs2_addr, ex_rd_addr));
  assign mc_issue  = id_valid && id_is_mc && (MC_LAT > 1);
  assign run_state = (state == RUN);

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    ex_hold   = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    reg1_sel  = 1'b0;
    reg2_sel  = 1'b0;
    if (!rst) begin
      if (mem_stall || !run_state) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        ex_hold  = 1'b1;
      end else begin
        reg1_sel = wb_wb_en && src_hit(id_rs1_use, id_rs1_addr, wb_rd_addr);
        reg2_sel = wb_wb_en && src_hit(id_rs2_use, id_rs2_addr, wb_rd_addr);
        if (branch_taken_ex) begin
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
        end else if (load_use) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end
      end
    end
  end

  // FSM and mc_cnt hold on every frozen cycle; a branch or load-use in RUN
  // suppresses the multi-cycle issue because the ID instruction does not advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      mc_cnt <= 4'd0;
    end else if (!mem_stall) begin
      case (state)
        RUN: begin
          if (!branch_taken_ex && !load_use && mc_issue) begin
            state  <= MC_BUSY;
            mc_cnt <= 4'(MC_LAT - 1);
          end
        end
        MC_BUSY: begin
          if (mc_cnt <= 4'd1) begin
            state  <= RUN;
            mc_cnt <= 4'd0;
          end else begin
            mc_cnt <= mc_cnt - 4'd1;
          end
        end
        default: begin
          state  <= RUN;
          mc_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign mc_busy = (state == MC_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_count  <= 16'd0;
    end else begin
      if (stall_id && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (flush_id && (flush_count != 16'hFFFF))
        flush_count <= flush_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table vectors, hand-written multi-cycle sequences and
// random traffic checked against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int MC_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs1_use, id_rs2_use, id_is_mc;
  logic [5:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr, wb_rd_addr;
  logic        ex_wb_en, ex_is_load, wb_wb_en, branch_taken_ex, mem_stall;
  logic        stall_if, stall_id, ex_hold, bubble_ex, flush_id;
  logic        reg1_sel, reg2_sel, mc_busy;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  hazard_ctrl #(.MC_LAT(MC_LAT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use), .id_is_mc(id_is_mc),
    .ex_rd_addr(ex_rd_addr), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load),
    .wb_rd_addr(wb_rd_addr), .wb_wb_en(wb_wb_en),
    .branch_taken_ex(branch_taken_ex), .mem_stall(mem_stall),
    .stall_if(stall_if), .stall_id(stall_id), .ex_hold(ex_hold),
    .bubble_ex(bubble_ex), .flush_id(flush_id),
    .reg1_sel(reg1_sel), .reg2_sel(reg2_sel), .mc_busy(mc_busy),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- stimulus record ----------------
  typedef struct {
    logic       vld;
    logic [5:0] rs1, rs2;
    logic       u1, u2, mc;
    logic [5:0] ex_rd;
    logic       ex_wb, ex_ld;
    logic [5:0] wb_rd;
    logic       wb_en, br, ms;
    logic [6:0] exp;  // {stall_if,stall_id,ex_hold,bubble_ex,flush_id,reg1_sel,reg2_sel}
  } vec_t;

  // ---------------- scoreboard / model state ----------------
  logic [6:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         busy_left = 0;     // remaining MC_BUSY cycles still owed
  longint     m_stall = 0;
  longint     m_flush = 0;
  logic       last_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t idle();
    vec_t v;
    v = '{vld:1'b1, rs1:6'd1, rs2:6'd2, u1:1'b1, u2:1'b1, mc:1'b0, ex_rd:6'd3,
          ex_wb:1'b1, ex_ld:1'b0, wb_rd:6'd4, wb_en:1'b1, br:1'b0, ms:1'b0, exp:7'd0};
    return v;
  endfunction

  function automatic logic hit(input logic u, input logic [5:0] s, input logic [5:0] d);
    return u && s == d && d != 6'd0;
  endfunction

  function automatic logic is_load_use(input vec_t v);
    return v.vld && v.ex_ld && v.ex_wb &&
           (hit(v.u1, v.rs1, v.ex_rd) || hit(v.u2, v.rs2, v.ex_rd));
  endfunction

  // Expected controls straight from the rules: freeze, then busy, then RUN priorities.
  function automatic logic [6:0] model_ctrl(input vec_t v, input int left);
    logic [6:0] r;
    if (v.ms || left > 0) return 7'b1110000;
    r = 7'd0;
    r[1] = v.wb_en && hit(v.u1, v.rs1, v.wb_rd);
    r[0] = v.wb_en && hit(v.u2, v.rs2, v.wb_rd);
    if (v.br)                  r[6:2] = 5'b00011;
    else if (is_load_use(v))   r[6:2] = 5'b11010;
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic apply(input vec_t v);
    id_valid = v.vld; id_rs1_addr = v.rs1; id_rs2_addr = v.rs2;
    id_rs1_use = v.u1; id_rs2_use = v.u2; id_is_mc = v.mc;
    ex_rd_addr = v.ex_rd; ex_wb_en = v.ex_wb; ex_is_load = v.ex_ld;
    wb_rd_addr = v.wb_rd; wb_wb_en = v.wb_en;
    branch_taken_ex = v.br; mem_stall = v.ms;
  endtask

  // One clock: drive, compare at negedge, advance model at posedge.
  task automatic step(input vec_t v, input bit use_tbl, input string tag);
    logic [6:0] act, e;
    apply(v);
    e = model_ctrl(v, busy_left);
    exp_q.push_back(e);
    @(negedge clk);
    act = {stall_if, stall_id, ex_hold, bubble_ex, flush_id, reg1_sel, reg2_sel};
    check({tag, "_ctrl"}, 32'(act), 32'(exp_q.pop_front()));
    if (use_tbl) check({tag, "_tbl"}, 32'(act), 32'(v.exp));
    check({tag, "_mc_busy"}, 32'(mc_busy), 32'(busy_left > 0));
    check({tag, "_stall_cycles"}, stall_cycles, 32'(m_stall));
    check({tag, "_flush_count"}, 32'(flush_count), 32'(m_flush));
    last_busy = mc_busy;
    @(posedge clk);
    if (e[5] && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (e[2] && m_flush < 64'hFFFF) m_flush++;
    if (!v.ms) begin
      if (busy_left > 0) busy_left--;
      else if (!v.br && !is_load_use(v) && v.vld && v.mc && MC_LAT > 1)
        busy_left = MC_LAT - 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(idle());
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", 32'({stall_if, stall_id, ex_hold, bubble_ex, flush_id, reg1_sel, reg2_sel}), 32'd0);
    check("rst_mc_busy", 32'(mc_busy), 32'd0);
    check("rst_counters", stall_cycles | 32'(flush_count), 32'd0);
    busy_left = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- test ----------------
  vec_t tbl[12];
  vec_t v;
  int   cnt;
  logic [5:0] pool[6];

  initial begin
    // Table of single-cycle vectors, all applied from RUN with no MC issue.
    for (int i = 0; i < 12; i++) tbl[i] = idle();
    tbl[0].rs1 = 6'd5;  tbl[0].ex_rd = 6'd5;  tbl[0].ex_ld = 1'b1; tbl[0].exp = 7'b1101000;
    tbl[1].rs1 = 6'd0;  tbl[1].ex_rd = 6'd0;  tbl[1].ex_ld = 1'b1; tbl[1].exp = 7'b0000000;
    tbl[2].rs2 = 6'd32; tbl[2].ex_rd = 6'd32; tbl[2].ex_ld = 1'b1; tbl[2].exp = 7'b1101000;
    tbl[3].rs1 = 6'd33; tbl[3].wb_rd = 6'd33; tbl[3].exp = 7'b0000010;
    tbl[4].rs1 = 6'd5;  tbl[4].ex_rd = 6'd5;  tbl[4].ex_ld = 1'b1; tbl[4].br = 1'b1;
    tbl[4].exp = 7'b0001100;
    tbl[5].rs1 = 6'd5;  tbl[5].ex_rd = 6'd5;  tbl[5].ex_ld = 1'b1; tbl[5].ms = 1'b1;
    tbl[5].exp = 7'b1110000;
    tbl[6].rs1 = 6'd33; tbl[6].wb_rd = 6'd33; tbl[6].ms = 1'b1; tbl[6].exp = 7'b1110000;
    tbl[7].rs2 = 6'd9;  tbl[7].wb_rd = 6'd9;  tbl[7].u2 = 1'b0; tbl[7].exp = 7'b0000000;
    tbl[8].rs1 = 6'd7;  tbl[8].ex_rd = 6'd7;  tbl[8].ex_ld = 1'b1; tbl[8].ex_wb = 1'b0;
    tbl[8].exp = 7'b0000000;
    tbl[9].rs1 = 6'd7;  tbl[9].ex_rd = 6'd7;  tbl[9].ex_ld = 1'b1; tbl[9].vld = 1'b0;
    tbl[9].wb_en = 1'b0; tbl[9].exp = 7'b0000000;
    tbl[10].rs1 = 6'd0; tbl[10].wb_rd = 6'd0; tbl[10].exp = 7'b0000000;
    tbl[11].rs2 = 6'd32; tbl[11].wb_rd = 6'd32; tbl[11].exp = 7'b0000001;

    do_reset();
    for (int i = 0; i < 12; i++) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Load-use: exactly one stall cycle, then the load has moved to MEM.
    do_reset();
    v = tbl[0]; step(v, 1'b1, "lu_stall");
    v = idle(); step(v, 1'b0, "lu_after");
    check("lu_stall_cycles", stall_cycles, 32'd1);

    // Multi-cycle op: three busy cycles.
    do_reset();
    v = idle(); v.mc = 1'b1; step(v, 1'b0, "mc_issue");
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(idle(), 1'b0, "mc_run");
      if (last_busy) cnt++;
      else break;
    end
    check("mc_busy_cycles", 32'(cnt), 32'd3);
    check("mc_stall_cycles", stall_cycles, 32'd3);

    // Same with a two-cycle freeze in the middle: five busy cycles.
    do_reset();
    v = idle(); v.mc = 1'b1; step(v, 1'b0, "mcs_issue");
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      v = idle(); v.ms = (i == 1 || i == 2);
      step(v, 1'b0, "mcs_run");
      if (last_busy) cnt++;
      else break;
    end
    check("mcs_busy_cycles", 32'(cnt), 32'd5);

    // Issue with mem_stall held: transition deferred until the freeze lifts.
    do_reset();
    v = idle(); v.mc = 1'b1; v.ms = 1'b1; step(v, 1'b0, "mcd_frozen");
    v.ms = 1'b0; step(v, 1'b0, "mcd_issue");
    step(idle(), 1'b0, "mcd_busy");
    check("mcd_busy", 32'(last_busy), 32'd1);

    // Branch and load-use together: flush wins, flush_count counts one.
    do_reset();
    step(tbl[4], 1'b1, "br_lu");
    step(idle(), 1'b0, "br_after");
    check("br_flush_count", 32'(flush_count), 32'd1);

    // Freeze during load-use, bubble lands in the first unfrozen cycle.
    do_reset();
    step(tbl[5], 1'b1, "msl_frozen");
    step(tbl[0], 1'b1, "msl_bubble");

    // Asynchronous reset in the middle of MC_BUSY.
    do_reset();
    v = idle(); v.mc = 1'b1; step(v, 1'b0, "ar_issue");
    step(idle(), 1'b0, "ar_busy");
    apply(idle());
    @(negedge clk);
    check("ar_busy_before", 32'(mc_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_ctrl", 32'({stall_if, stall_id, ex_hold, bubble_ex, flush_id, reg1_sel, reg2_sel}), 32'd0);
    check("ar_mc_busy", 32'(mc_busy), 32'd0);
    check("ar_counters", stall_cycles | 32'(flush_count), 32'd0);
    busy_left = 0; m_stall = 0; m_flush = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    v = idle(); v.exp = 7'd0; step(v, 1'b1, "ar_normal");

    // Random traffic against the model, addresses from a small colliding pool.
    pool = '{6'd0, 6'd5, 6'd31, 6'd32, 6'd33, 6'd63};
    for (int i = 0; i < 400; i++) begin
      v.vld   = ($urandom_range(0, 7) != 0);
      v.rs1   = pool[$urandom_range(0, 5)];
      v.rs2   = pool[$urandom_range(0, 5)];
      v.u1    = $urandom_range(0, 1);
      v.u2    = $urandom_range(0, 1);
      v.mc    = ($urandom_range(0, 5) == 0);
      v.ex_rd = pool[$urandom_range(0, 5)];
      v.ex_wb = ($urandom_range(0, 3) != 0);
      v.ex_ld = $urandom_range(0, 1);
      v.wb_rd = pool[$urandom_range(0, 5)];
      v.wb_en = $urandom_range(0, 1);
      v.br    = ($urandom_range(0, 5) == 0);
      v.ms    = ($urandom_range(0, 4) == 0);
      v.exp   = 7'd0;
      step(v, 1'b0, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
